// File: rtl/pipe_fifo_if.sv
// pipe_fifo_if: handshake bundle between an upstream stage, the pipe_fifo
// buffer and the downstream stage. The count_out signal only exists when
// PIPE_FIFO_CNT_EN is defined.
interface pipe_fifo_if #(
    parameter type T     = logic,
    parameter int  DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic flush_in;
    logic write_in;
    T     data_in;
    logic full_out;
    logic read_in;
    T     data_out;
    logic valid_out;
`ifdef PIPE_FIFO_CNT_EN
    logic [CW-1:0] count_out;
`endif

    // Producer/consumer side: drives the requests and observes the buffer state.
    modport master (
        output flush_in,
        output write_in,
        output data_in,
        output read_in,
`ifdef PIPE_FIFO_CNT_EN
        input  count_out,
`endif
        input  full_out,
        input  data_out,
        input  valid_out
    );

    // Buffer side: receives the requests and reports its state.
    modport slave (
        input  flush_in,
        input  write_in,
        input  data_in,
        input  read_in,
`ifdef PIPE_FIFO_CNT_EN
        output count_out,
`endif
        output full_out,
        output data_out,
        output valid_out
    );
endinterface

// File: rtl/pipe_fifo.sv
// pipe_fifo: DEPTH-entry elastic buffer between two pipeline stages.
// The head entry is always presented on data_out straight from storage.
// A full buffer that is being read in the same cycle still accepts a write.
// flush_in squashes every entry synchronously; reset_in clears everything
// asynchronously.
// Optional feature macro: PIPE_FIFO_CNT_EN adds count_out and
// simulation-only protocol assertions.
module pipe_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 2
) (
    input  logic       clk_in,
    input  logic       reset_in,
    pipe_fifo_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    T              r_mem [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_cnt;

    logic          w_valid;
    logic          w_isFull;
    logic          w_wrAccept;
    logic          w_rdAccept;
    logic [PW-1:0] w_wrPtrNext;
    logic [PW-1:0] w_rdPtrNext;

    // Handshake decode: a full buffer only refuses a write when nothing leaves this cycle.
    always_comb begin
        w_valid     = (r_cnt != '0);
        w_isFull    = (r_cnt == DEPTH_CNT);
        w_wrAccept  = bus.write_in & (!w_isFull | bus.read_in);
        w_rdAccept  = bus.read_in & w_valid;
        w_wrPtrNext = (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + 1'b1;
        w_rdPtrNext = (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + 1'b1;
    end

    // Pointer and occupancy state; flush rewinds both pointers and empties the buffer.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_cnt   <= '0;
        end else if (bus.flush_in) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_wrAccept) begin
                r_wrPtr <= w_wrPtrNext;
            end
            if (w_rdAccept) begin
                r_rdPtr <= w_rdPtrNext;
            end
            if (w_wrAccept && !w_rdAccept) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_rdAccept && !w_wrAccept) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Payload storage; a flush leaves old contents in place but drops the same-cycle write.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wrAccept && !bus.flush_in) begin
            r_mem[r_wrPtr] <= bus.data_in;
        end
    end

    assign bus.valid_out = w_valid;
    assign bus.full_out  = w_isFull & !bus.read_in;
    assign bus.data_out  = r_mem[r_rdPtr];

`ifdef PIPE_FIFO_CNT_EN
    assign bus.count_out = r_cnt;

    // Protocol checks: upstream must respect full_out, downstream must respect valid_out.
    a_noWriteWhenFull : assert property (@(posedge clk_in) disable iff (reset_in)
        !(bus.write_in && bus.full_out));
    a_noReadWhenEmpty : assert property (@(posedge clk_in) disable iff (reset_in)
        !(bus.read_in && !bus.valid_out));
`endif
endmodule

// File: tb/tb_pipe_fifo.sv
// tb_pipe_fifo: directed self-checking bench for pipe_fifo at DEPTH 4, 3 and 1.
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// too, well away from the next edge.
module tb_pipe_fifo;
    typedef logic [7:0] byte_t;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    pipe_fifo_if #(.T(byte_t), .DEPTH(4)) ifA ();
    pipe_fifo_if #(.T(byte_t), .DEPTH(3)) ifB ();
    pipe_fifo_if #(.T(byte_t), .DEPTH(1)) ifC ();

    pipe_fifo #(.T(byte_t), .DEPTH(4)) dutA (.clk_in(clock), .reset_in(reset), .bus(ifA));
    pipe_fifo #(.T(byte_t), .DEPTH(3)) dutB (.clk_in(clock), .reset_in(reset), .bus(ifB));
    pipe_fifo #(.T(byte_t), .DEPTH(1)) dutC (.clk_in(clock), .reset_in(reset), .bus(ifC));

    // Free-running clock, period 10.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance one rising edge and settle just past it.
    task automatic applyStimulus();
        @(posedge clock);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Directed scenario sequence.
    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        {ifA.flush_in, ifA.write_in, ifA.read_in, ifA.data_in} = '0;
        {ifB.flush_in, ifB.write_in, ifB.read_in, ifB.data_in} = '0;
        {ifC.flush_in, ifC.write_in, ifC.read_in, ifC.data_in} = '0;
        #1;
        checkOutput("rst_valid", 32'(ifA.valid_out), 32'h0);
        checkOutput("rst_full",  32'(ifA.full_out),  32'h0);
        checkOutput("rst_data",  32'(ifA.data_out),  32'h0);
        applyStimulus();
        applyStimulus();
        reset = 1'b0;
        #1;
        checkOutput("rst_rel_valid", 32'(ifA.valid_out), 32'h0);
        checkOutput("rst_rel_full",  32'(ifA.full_out),  32'h0);
`ifdef PIPE_FIFO_CNT_EN
        checkOutput("rst_count", 32'(ifA.count_out), 32'h0);
`endif

        // Fill DEPTH=4 with A1..A4.
        ifA.write_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            ifA.data_in = 8'hA0 + 8'(i);
            applyStimulus();
            checkOutput($sformatf("fill%0d_valid", i), 32'(ifA.valid_out), 32'h1);
            checkOutput($sformatf("fill%0d_head", i),  32'(ifA.data_out),  32'hA1);
            checkOutput($sformatf("fill%0d_full", i),  32'(ifA.full_out),  (i == 4) ? 32'h1 : 32'h0);
        end
`ifdef PIPE_FIFO_CNT_EN
        checkOutput("fill_count", 32'(ifA.count_out), 32'h4);
`else
        // A fifth write against a full buffer must be dropped.
        ifA.data_in = 8'hA5;
        applyStimulus();
        checkOutput("drop_full", 32'(ifA.full_out), 32'h1);
        checkOutput("drop_head", 32'(ifA.data_out), 32'hA1);
`endif
        ifA.write_in = 1'b0;

        // Drain: A1, A2, A3, A4, then empty.
        ifA.read_in = 1'b1;
        #1;
        checkOutput("drain_full_rd", 32'(ifA.full_out), 32'h0);
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("drain%0d_data", i),  32'(ifA.data_out),  32'hA0 + 32'(i));
            checkOutput($sformatf("drain%0d_valid", i), 32'(ifA.valid_out), 32'h1);
            applyStimulus();
        end
        checkOutput("drain_empty", 32'(ifA.valid_out), 32'h0);
`ifndef PIPE_FIFO_CNT_EN
        // A read against an empty buffer must not move the read pointer.
        applyStimulus();
        checkOutput("empty_rd_valid", 32'(ifA.valid_out), 32'h0);
`endif
        ifA.read_in = 1'b0;

        // Refill, then read and write together while full.
        ifA.write_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            ifA.data_in = 8'hA0 + 8'(i);
            applyStimulus();
        end
        checkOutput("refill_full", 32'(ifA.full_out), 32'h1);
        ifA.read_in = 1'b1;
        ifA.data_in = 8'hB0;
        #1;
        checkOutput("rw_full_same_cycle", 32'(ifA.full_out), 32'h0);
        applyStimulus();
        ifA.write_in = 1'b0;
        #1;
`ifdef PIPE_FIFO_CNT_EN
        checkOutput("rw_count", 32'(ifA.count_out), 32'h4);
`endif
        checkOutput("rw_order0", 32'(ifA.data_out), 32'hA2);
        applyStimulus();
        checkOutput("rw_order1", 32'(ifA.data_out), 32'hA3);
        applyStimulus();
        checkOutput("rw_order2", 32'(ifA.data_out), 32'hA4);
        applyStimulus();
        checkOutput("rw_order3", 32'(ifA.data_out), 32'hB0);
        applyStimulus();
        checkOutput("rw_empty", 32'(ifA.valid_out), 32'h0);
        ifA.read_in = 1'b0;

        // Asynchronous reset mid-stream with three entries held.
        ifA.write_in = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            ifA.data_in = 8'hC0 + 8'(i);
            applyStimulus();
        end
        ifA.write_in = 1'b0;
        checkOutput("pre_async_valid", 32'(ifA.valid_out), 32'h1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("async_valid", 32'(ifA.valid_out), 32'h0);
        checkOutput("async_full",  32'(ifA.full_out),  32'h0);
        checkOutput("async_data",  32'(ifA.data_out),  32'h0);
`ifdef PIPE_FIFO_CNT_EN
        checkOutput("async_count", 32'(ifA.count_out), 32'h0);
`endif
        applyStimulus();
        reset = 1'b0;
        #1;

        // Flush with a same-cycle write that must be dropped.
        ifA.write_in = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            ifA.data_in = 8'(8'h11 * i);
            applyStimulus();
        end
`ifdef PIPE_FIFO_CNT_EN
        checkOutput("pre_flush_count", 32'(ifA.count_out), 32'h3);
`endif
        ifA.flush_in = 1'b1;
        ifA.data_in  = 8'hCC;
        applyStimulus();
        ifA.flush_in = 1'b0;
        ifA.write_in = 1'b0;
        #1;
        checkOutput("flush_valid", 32'(ifA.valid_out), 32'h0);
        checkOutput("flush_full",  32'(ifA.full_out),  32'h0);
`ifdef PIPE_FIFO_CNT_EN
        checkOutput("flush_count", 32'(ifA.count_out), 32'h0);
`endif
        ifA.write_in = 1'b1;
        ifA.data_in  = 8'hDD;
        applyStimulus();
        ifA.write_in = 1'b0;
        checkOutput("post_flush_head", 32'(ifA.data_out), 32'hDD);
        ifA.read_in = 1'b1;
        applyStimulus();
        ifA.read_in = 1'b0;
        checkOutput("post_flush_empty", 32'(ifA.valid_out), 32'h0);

        // DEPTH=3 streaming: prime two, then read and write every cycle.
        ifB.write_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ifB.data_in = 8'h50 + 8'(i);
            ifB.read_in = (i >= 2);
            applyStimulus();
            checkOutput($sformatf("wrap%0d_head", i),  32'(ifB.data_out),  32'h50 + 32'((i == 0) ? 0 : i - 1));
            checkOutput($sformatf("wrap%0d_valid", i), 32'(ifB.valid_out), 32'h1);
        end
        ifB.write_in = 1'b0;
        ifB.read_in  = 1'b1;
        applyStimulus();
        checkOutput("wrap_tail", 32'(ifB.data_out), 32'h59);
        applyStimulus();
        checkOutput("wrap_empty", 32'(ifB.valid_out), 32'h0);
        ifB.read_in = 1'b0;

        // DEPTH=1 behaves as the single-entry stage register.
        checkOutput("d1_init_full", 32'(ifC.full_out), 32'h0);
        ifC.write_in = 1'b1;
        ifC.data_in  = 8'h71;
        applyStimulus();
        ifC.write_in = 1'b0;
        checkOutput("d1_w_valid", 32'(ifC.valid_out), 32'h1);
        checkOutput("d1_w_data",  32'(ifC.data_out),  32'h71);
        checkOutput("d1_w_full",  32'(ifC.full_out),  32'h1);
        ifC.read_in = 1'b1;
        #1;
        checkOutput("d1_rd_full", 32'(ifC.full_out), 32'h0);
        applyStimulus();
        ifC.read_in = 1'b0;
        checkOutput("d1_rd_valid", 32'(ifC.valid_out), 32'h0);
        ifC.write_in = 1'b1;
        ifC.data_in  = 8'h73;
        applyStimulus();
        checkOutput("d1_w2_data", 32'(ifC.data_out), 32'h73);
        ifC.read_in = 1'b1;
        ifC.data_in = 8'h74;
        #1;
        checkOutput("d1_rw_full", 32'(ifC.full_out), 32'h0);
        applyStimulus();
        ifC.write_in = 1'b0;
        checkOutput("d1_rw_data",  32'(ifC.data_out),  32'h74);
        checkOutput("d1_rw_valid", 32'(ifC.valid_out), 32'h1);
        applyStimulus();
        ifC.read_in = 1'b0;
        checkOutput("d1_end_valid", 32'(ifC.valid_out), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
